// File: rtl/key_exp_pkg.sv
// Shared types and constants for the AES-128 key expansion controller.
package key_exp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROT,
        S_EXP,
        S_DONE
    } keyexp_state_t;

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RCON_POLY = 8'h1B;
    localparam int         AES_KEY_WORDS = 44;

    // GF(2^8) multiply-by-2 used to step the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// Control/strobe bundle between the key expansion controller (master)
// and the key array / clock gates / round-key memory (slave).
// Optional macro KEYEXP_ABORT_EN adds the abort input.
interface key_expansion_ctrl_if;
    logic       start;
    logic       key_rd;
    logic       ff_en;
    logic       scanff_en;
    logic       se;
    logic       key_gen_sel;
    logic [7:0] rcon;
    logic       rcon_en;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [3:0] round_idx;
    logic       busy;
    logic       done;
`ifdef KEYEXP_ABORT_EN
    logic       abort;

    modport master (input start, abort,
                    output key_rd, ff_en, scanff_en, se, key_gen_sel, rcon, rcon_en,
                           mem_we, mem_addr, round_idx, busy, done);
    modport slave  (output start, abort,
                    input key_rd, ff_en, scanff_en, se, key_gen_sel, rcon, rcon_en,
                          mem_we, mem_addr, round_idx, busy, done);
`else
    modport master (input start,
                    output key_rd, ff_en, scanff_en, se, key_gen_sel, rcon, rcon_en,
                           mem_we, mem_addr, round_idx, busy, done);
    modport slave  (output start,
                    input key_rd, ff_en, scanff_en, se, key_gen_sel, rcon, rcon_en,
                          mem_we, mem_addr, round_idx, busy, done);
`endif
endinterface

// File: rtl/key_expansion_ctrl_rcon_gen.sv
// Round-constant register: re-initialised to 01, stepped by xtime once per round.
module rcon_gen
    import key_exp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       adv,
    output logic [7:0] rcon
);
    logic [7:0] rcon_d, rcon_q;

    // init wins over advance so an abort/IDLE entry always restarts the sequence
    always_comb begin
        rcon_d = rcon_q;
        if (init)
            rcon_d = AES_RCON_INIT;
        else if (adv)
            rcon_d = xtime(rcon_q);
    end

    // rcon register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcon_q <= AES_RCON_INIT;
        else        rcon_q <= rcon_d;
    end

    assign rcon = rcon_q;
endmodule

// File: rtl/key_expansion_ctrl.sv
// Byte-serial AES-128 key expansion sequencer: LOAD the cipher key, then
// alternate ROT (store 4 words) and EXP (16 feedback shifts) until all
// 44 words are written. Optional macro KEYEXP_ABORT_EN enables abort.
module key_expansion_ctrl
    import key_exp_pkg::*;
#(
    parameter int NUM_ROUNDS  = 10,
    parameter int LOAD_CYCLES = 16,
    parameter int ROT_CYCLES  = 4,
    parameter int EXP_CYCLES  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    key_expansion_ctrl_if.master bus
);
    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [3:0] ROT_LAST  = 4'(ROT_CYCLES - 1);
    localparam logic [3:0] EXP_LAST  = 4'(EXP_CYCLES - 1);
    localparam logic [3:0] RND_LAST  = 4'(NUM_ROUNDS);

    keyexp_state_t state_d, state_q;
    logic [3:0]    cyc_cnt_d, cyc_cnt_q;
    logic [3:0]    round_idx_d, round_idx_q;
    logic          rcon_init, rcon_adv;
    logic [7:0]    rcon_w;
    logic          abort_req;

`ifdef KEYEXP_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // next state, cycle counter and round index
    always_comb begin
        state_d     = state_q;
        cyc_cnt_d   = cyc_cnt_q + 4'd1;
        round_idx_d = round_idx_q;
        rcon_adv    = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_LOAD;
            S_LOAD: if (cyc_cnt_q == LOAD_LAST) state_d = S_ROT;
            S_ROT:  if (cyc_cnt_q == ROT_LAST)
                        state_d = (round_idx_q == RND_LAST) ? S_DONE : S_EXP;
            S_EXP:  if (cyc_cnt_q == EXP_LAST) begin
                        state_d  = S_ROT;
                        rcon_adv = 1'b1;
                        if (round_idx_q != RND_LAST) round_idx_d = round_idx_q + 4'd1;
                    end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides every transition, including the DONE exit
        if (abort_req && state_q != S_IDLE) state_d = S_IDLE;
        if (state_d != state_q) cyc_cnt_d = '0;
        if (state_d == S_IDLE) begin
            cyc_cnt_d   = '0;
            round_idx_d = '0;
        end
    end

    // rcon is held at its initial value whenever we are in or entering IDLE
    assign rcon_init = (state_q == S_IDLE) || (state_d == S_IDLE);

    // state, counter and round registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_cnt_q   <= '0;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_cnt_q   <= cyc_cnt_d;
            round_idx_q <= round_idx_d;
        end
    end

    rcon_gen u_rcon_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (rcon_init),
        .adv   (rcon_adv),
        .rcon  (rcon_w)
    );

    // output decode from registered state only
    always_comb begin
        bus.key_rd      = 1'b0;
        bus.ff_en       = 1'b0;
        bus.scanff_en   = 1'b0;
        bus.se          = 1'b0;
        bus.key_gen_sel = 1'b0;
        bus.rcon_en     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                bus.key_rd    = 1'b1;
                bus.ff_en     = 1'b1;
                bus.scanff_en = 1'b1;
                bus.busy      = 1'b1;
            end
            S_ROT: begin
                bus.scanff_en = 1'b1;
                bus.se        = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {round_idx_q, 2'b00} + {2'b00, cyc_cnt_q};
                bus.busy      = 1'b1;
            end
            S_EXP: begin
                bus.ff_en       = 1'b1;
                bus.scanff_en   = 1'b1;
                bus.key_gen_sel = 1'b1;
                bus.rcon_en     = (cyc_cnt_q == 4'd0);
                bus.busy        = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.round_idx = round_idx_q;
    assign bus.rcon      = rcon_w;
endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Scoreboard bench for key_expansion_ctrl: expected word addresses and
// round constants are queued per run and popped by an output monitor.
module tb_key_expansion_ctrl;
    import key_exp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    key_expansion_ctrl_if bus ();

    key_expansion_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         n_rcon_en = 0;
    int         exp_addr[$];
    logic [7:0] exp_rcon[$];
    logic [7:0] rcon_tbl[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_run();
        for (int a = 0; a < AES_KEY_WORDS; a++) exp_addr.push_back(a);
        for (int i = 0; i < 10; i++) exp_rcon.push_back(rcon_tbl[i]);
    endtask

    function automatic logic [8:0] strobes();
        return {bus.key_rd, bus.ff_en, bus.scanff_en, bus.se, bus.key_gen_sel,
                bus.rcon_en, bus.mem_we, bus.busy, bus.done};
    endfunction

    // monitor: pop expectations whenever the DUT writes a word or applies rcon
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                if (exp_addr.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL mem_we_unexpected: addr %0d with empty queue", bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, exp_addr.pop_front());
                end
                check("rot_decode", {bus.se, bus.scanff_en, bus.ff_en, bus.key_gen_sel}, 4'b1100);
            end
            if (bus.key_gen_sel)
                check("exp_decode", {bus.se, bus.ff_en, bus.scanff_en, bus.mem_we}, 4'b0110);
            if (bus.key_rd)
                check("load_decode", {bus.ff_en, bus.scanff_en, bus.se, bus.key_gen_sel}, 4'b1100);
            if (bus.rcon_en) begin
                n_rcon_en++;
                if (exp_rcon.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL rcon_en_unexpected: rcon %0h with empty queue", bus.rcon);
                end else begin
                    check("rcon", bus.rcon, exp_rcon.pop_front());
                end
            end
        end
    end

    // one full expansion; caller is at a negedge in an IDLE cycle
    task automatic run_full(input bit pester);
        int t;
        int kr;
        int ren0;
        bit got;
        t = 1; kr = 0; got = 1'b0; ren0 = n_rcon_en;
        push_run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = pester;
        while (t < 400) begin
            if (bus.key_rd) kr++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
        check("done_seen", got, 1);
        check("done_cycle", t, 221);
        check("key_rd_cycles", kr, 16);
        check("rcon_en_count", n_rcon_en - ren0, 10);
        check("addr_left", exp_addr.size(), 0);
        check("rcon_left", exp_rcon.size(), 0);
        exp_addr.delete();
        exp_rcon.delete();
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
        check("round_idx_cleared", bus.round_idx, 0);
        check("rcon_reinit", bus.rcon, 8'h01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_hi;
        int done_hi;
        bus.start = 1'b0;
`ifdef KEYEXP_ABORT_EN
        bus.abort = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #($urandom_range(3, 40));
        check("reset_strobes", strobes(), 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_round_idx", bus.round_idx, 0);
        check("reset_rcon", bus.rcon, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // idle with start low
        busy_hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.busy) busy_hi++;
        end
        check("idle_busy_cycles", busy_hi, 0);

        // plain run, run with start held through busy and DONE, then restart
        run_full(1'b0);
        run_full(1'b1);
        run_full(1'b0);

        // reset during round 5 EXP (cycle 125)
        push_run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (124) @(negedge clk);
        check("mid_round_idx", bus.round_idx, 5);
        check("mid_in_exp", bus.key_gen_sel, 1);
        check("mid_rcon", bus.rcon, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobes", strobes(), 0);
        check("rst_round_idx", bus.round_idx, 0);
        check("rst_rcon", bus.rcon, 8'h01);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_addr_left", exp_addr.size(), 20);
        check("rst_rcon_left", exp_rcon.size(), 4);
        exp_addr.delete();
        exp_rcon.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_full(1'b0);

`ifdef KEYEXP_ABORT_EN
        // abort during round 3 ROT (cycle 78, word 13)
        push_run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (77) @(negedge clk);
        check("abort_pre_we", bus.mem_we, 1);
        check("abort_pre_addr", bus.mem_addr, 13);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_strobes", strobes(), 0);
        check("abort_rcon", bus.rcon, 8'h01);
        check("abort_round_idx", bus.round_idx, 0);
        check("abort_addr_left", exp_addr.size(), 30);
        check("abort_rcon_left", exp_rcon.size(), 7);
        exp_addr.delete();
        exp_rcon.delete();
        done_hi = 0;
        busy_hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) done_hi++;
            if (bus.busy) busy_hi++;
        end
        check("abort_no_done", done_hi, 0);
        check("abort_stays_idle", busy_hi, 0);
`else
        done_hi = 0;
        run_full(1'b0);
`endif

        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
